wb_segment_feeder: RTL and testbench

Wishbone master that sits directly upstream of the 74HC164 byte shifter in the numeric display path. It holds a frame of NUM_DIGITS hex digits and encodes each digit to a 7-segment byte. It then issues one single-byte Wishbone write per digit to the shifter's slave port, one after another. Frames start on a software update strobe or on a periodic refresh timer.

---
 rtl/wb_segment_feeder.sv | 163 ++++++++++++++++
 tb/tb_wb_segment_feeder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_segment_feeder.sv
// Wishbone master that encodes a staged frame of hex digits to 7-segment bytes
// and writes them one byte at a time to the downstream HC164 shifter.
module wb_segment_feeder #(
   parameter int NUM_DIGITS     = 4,
   parameter int IDX_WIDTH      = 2,
   parameter int REFRESH_PERIOD = 0,
   parameter int REFRESH_WIDTH  = 16,
   parameter bit ACTIVE_LOW     = 1'b0
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic [4*NUM_DIGITS-1:0] i_digits,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic [NUM_DIGITS-1:0]   i_blank,
   input  logic                    i_update_stb,
   output logic                    o_wb_cyc,
   output logic                    o_wb_stb,
   output logic [7:0]              o_wb_data,
   input  logic                    i_wb_ack,
   input  logic                    i_wb_stall,
   output logic                    o_busy,
   output logic                    o_frame_done_stb
);

   localparam logic [IDX_WIDTH-1:0]     LAST_IDX     = IDX_WIDTH'(NUM_DIGITS - 1);
   localparam logic [REFRESH_WIDTH-1:0] REFRESH_LAST =
      (REFRESH_PERIOD > 0) ? REFRESH_WIDTH'(REFRESH_PERIOD - 1) : '0;

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2, DONE = 2'd3} state_t;

   state_t                    state;
   logic [4*NUM_DIGITS-1:0]   stage_digits, shadow_digits, load_digits;
   logic [NUM_DIGITS-1:0]     stage_dp, shadow_dp, load_dp;
   logic [NUM_DIGITS-1:0]     stage_blank, shadow_blank, load_blank;
   logic                      pending;
   logic                      refresh_hit;
   logic                      start;
   logic [IDX_WIDTH-1:0]      idx;
   logic [REFRESH_WIDTH-1:0]  refresh_cnt;

   function automatic logic [7:0] encode(input logic [3:0] hex, input logic dp,
                                         input logic blank);
      logic [6:0] seg;
      logic [7:0] byte_v;
      case (hex)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
      byte_v = blank ? 8'h00 : {dp, seg};
      return ACTIVE_LOW ? ~byte_v : byte_v;
   endfunction

   function automatic logic [7:0] digit_byte(input logic [4*NUM_DIGITS-1:0] digits,
                                             input logic [NUM_DIGITS-1:0]   dp,
                                             input logic [NUM_DIGITS-1:0]   blank,
                                             input logic [IDX_WIDTH-1:0]    k);
      return encode(digits[4*k +: 4], dp[k], blank[k]);
   endfunction

   // A strobe on the start cycle must win over older staged values.
   always_comb begin
      load_digits = i_update_stb ? i_digits : stage_digits;
      load_dp     = i_update_stb ? i_dp     : stage_dp;
      load_blank  = i_update_stb ? i_blank  : stage_blank;
      refresh_hit = (REFRESH_PERIOD > 0) && (refresh_cnt == REFRESH_LAST);
      start       = pending || i_update_stb || refresh_hit;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         stage_digits <= '0;
         stage_dp     <= '0;
         stage_blank  <= '0;
      end else if (i_update_stb) begin
         stage_digits <= i_digits;
         stage_dp     <= i_dp;
         stage_blank  <= i_blank;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state            <= IDLE;
         shadow_digits    <= '0;
         shadow_dp        <= '0;
         shadow_blank     <= '0;
         pending          <= 1'b0;
         idx              <= '0;
         refresh_cnt      <= '0;
         o_wb_cyc         <= 1'b0;
         o_wb_stb         <= 1'b0;
         o_wb_data        <= 8'h00;
         o_frame_done_stb <= 1'b0;
      end else begin
         o_frame_done_stb <= 1'b0;
         if (i_update_stb) pending <= 1'b1;
         case (state)
            IDLE: begin
               o_wb_cyc <= 1'b0;
               o_wb_stb <= 1'b0;
               if (start) begin
                  shadow_digits <= load_digits;
                  shadow_dp     <= load_dp;
                  shadow_blank  <= load_blank;
                  pending       <= 1'b0;
                  refresh_cnt   <= '0;
                  idx           <= LAST_IDX;
                  o_wb_cyc      <= 1'b1;
                  o_wb_stb      <= 1'b1;
                  o_wb_data     <= digit_byte(load_digits, load_dp, load_blank, LAST_IDX);
                  state         <= REQ;
               end else begin
                  refresh_cnt <= refresh_cnt + 1'b1;
               end
            end
            REQ: begin
               if (!i_wb_stall) begin
                  o_wb_stb <= 1'b0;
                  state    <= ACK;
               end
            end
            ACK: begin
               if (i_wb_ack) begin
                  if (idx == '0) begin
                     o_wb_cyc         <= 1'b0;
                     o_frame_done_stb <= 1'b1;
                     state            <= DONE;
                  end else begin
                     idx       <= idx - 1'b1;
                     o_wb_stb  <= 1'b1;
                     o_wb_data <= digit_byte(shadow_digits, shadow_dp, shadow_blank,
                                             idx - 1'b1);
                     state     <= REQ;
                  end
               end
            end
            DONE: state <= IDLE;
            default: begin
               o_wb_cyc <= 1'b0;
               o_wb_stb <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign o_busy = o_wb_cyc;

endmodule

// File: tb/tb_wb_segment_feeder.sv
// Bench for wb_segment_feeder: two instances (plain / active-low with auto-refresh),
// randomized stalling slaves, and a frame scoreboard fed by the stimulus.
module tb_wb_segment_feeder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] digits [2];
   logic [3:0]  dp     [2];
   logic [3:0]  blank  [2];
   logic        upd    [2];
   logic        cyc    [2];
   logic        stb    [2];
   logic [7:0]  data   [2];
   logic        ack    [2];
   logic        stall  [2];
   logic        busy   [2];
   logic        done   [2];

   int n_total = 0;
   int n_pass  = 0;

   // expected frames, first-sent byte in bits 31:24
   logic [31:0] exp_q [2][$];
   logic [15:0] stg_d [2];
   logic [3:0]  stg_p [2];
   logic [3:0]  stg_b [2];

   localparam logic [7:0] SEG [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                       8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   wb_segment_feeder #(.NUM_DIGITS(4), .IDX_WIDTH(2), .REFRESH_PERIOD(0),
                       .REFRESH_WIDTH(16), .ACTIVE_LOW(1'b0)) dut0 (
      .i_clk(clk), .i_reset_n(rst_n), .i_digits(digits[0]), .i_dp(dp[0]),
      .i_blank(blank[0]), .i_update_stb(upd[0]), .o_wb_cyc(cyc[0]), .o_wb_stb(stb[0]),
      .o_wb_data(data[0]), .i_wb_ack(ack[0]), .i_wb_stall(stall[0]), .o_busy(busy[0]),
      .o_frame_done_stb(done[0]));

   wb_segment_feeder #(.NUM_DIGITS(4), .IDX_WIDTH(2), .REFRESH_PERIOD(50),
                       .REFRESH_WIDTH(16), .ACTIVE_LOW(1'b1)) dut1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_digits(digits[1]), .i_dp(dp[1]),
      .i_blank(blank[1]), .i_update_stb(upd[1]), .o_wb_cyc(cyc[1]), .o_wb_stb(stb[1]),
      .o_wb_data(data[1]), .i_wb_ack(ack[1]), .i_wb_stall(stall[1]), .o_busy(busy[1]),
      .o_frame_done_stb(done[1]));

   function automatic logic [31:0] model_frame(input logic [15:0] d, input logic [3:0] p,
                                               input logic [3:0] b, input bit al);
      logic [31:0] f = '0;
      logic [7:0]  v;
      for (int k = 3; k >= 0; k--) begin
         v = b[k] ? 8'h00 : (SEG[d[4*k +: 4]] | {p[k], 7'b0});
         if (al) v = ~v;
         f = {f[23:0], v};
      end
      return f;
   endfunction

   task automatic check(input int inst, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL dut%0d %s: got %0h expected %0h at %0t", inst, name, act, exp, $time);
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic strobe(input int i, input logic [15:0] d, input logic [3:0] p,
                         input logic [3:0] b);
      logic [31:0] f;
      f = model_frame(d, p, b, i == 1);
      digits[i] = d; dp[i] = p; blank[i] = b; upd[i] = 1'b1;
      stg_d[i] = d; stg_p[i] = p; stg_b[i] = b;
      if (exp_q[i].size() > 0) exp_q[i][exp_q[i].size()-1] = f;
      else exp_q[i].push_back(f);
      tick();
      upd[i] = 1'b0;
   endtask

   task automatic wait_ack(input int i);
      for (int n = 0; n < 1000; n++) begin
         tick();
         if (ack[i]) break;
      end
      check(i, "ack_seen", ack[i], 1);
   endtask

   task automatic wait_done(input int i);
      for (int n = 0; n < 3000; n++) begin
         tick();
         if (done[i]) break;
      end
      check(i, "done_seen", done[i], 1);
   endtask

   task automatic wait_idle(input int i);
      for (int n = 0; n < 3000; n++) begin
         if (!cyc[i] && !done[i] && exp_q[i].size() == 0) break;
         tick();
      end
      check(i, "idle_reached", cyc[i], 0);
   endtask

   // Slave: ack one cycle after acceptance, then hold stall for a random 0..20 cycles.
   task automatic slave(input int i);
      bit acc = 1'b0;
      int cnt = 0;
      ack[i] = 1'b0;
      stall[i] = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            acc = 1'b0; cnt = 0; ack[i] = 1'b0; stall[i] = 1'b0;
            continue;
         end
         ack[i] = acc;
         if (acc) cnt = $urandom_range(0, 20);
         stall[i] = (cnt > 0) || ($urandom_range(0, 4) == 0);
         if (cnt > 0) cnt--;
         acc = cyc[i] && stb[i] && !stall[i];
      end
   endtask

   task automatic monitor(input int i);
      logic [31:0] frame = '0;
      int nbytes = 0;
      int idle = 0;
      bit in_frame = 1'b0, prev_cyc = 1'b0, dropped = 1'b0, was_rst;
      forever begin
         @(posedge clk);
         was_rst = !rst_n;
         @(negedge clk);
         #1;
         if (was_rst) begin
            in_frame = 1'b0; prev_cyc = 1'b0; idle = 1;
            exp_q[i].delete();
            stg_d[i] = '0; stg_p[i] = '0; stg_b[i] = '0;
            continue;
         end
         if (cyc[i] && !prev_cyc) begin
            if (i == 0) check(i, "frame_requested", exp_q[0].size() != 0, 1);
            if (exp_q[i].size() > 0) frame = exp_q[i].pop_front();
            else begin
               check(i, "refresh_gap", idle, 50);
               frame = model_frame(stg_d[i], stg_p[i], stg_b[i], 1'b1);
            end
            in_frame = 1'b1; nbytes = 0; dropped = 1'b0;
         end
         if (in_frame && !cyc[i] && !done[i]) dropped = 1'b1;
         if (cyc[i] && stb[i] && !stall[i]) begin
            if (nbytes < 4) check(i, $sformatf("byte%0d", nbytes), data[i], frame[8*(3-nbytes) +: 8]);
            else check(i, "extra_byte", nbytes, 3);
            check(i, "busy", busy[i], 1);
            nbytes++;
         end
         if (done[i]) begin
            check(i, "done_in_frame", in_frame, 1);
            check(i, "bytes_per_frame", nbytes, 4);
            check(i, "cyc_held", dropped, 0);
            check(i, "cyc_low_at_done", cyc[i], 0);
            in_frame = 1'b0;
         end
         idle = (!cyc[i] && !done[i]) ? idle + 1 : 0;
         prev_cyc = cyc[i];
      end
   endtask

   initial slave(0);
   initial slave(1);
   initial monitor(0);
   initial monitor(1);

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic dut0_seq();
      strobe(0, 16'h1234, 4'b0000, 4'b0000);
      check(0, "latency_cyc", cyc[0], 1);
      check(0, "latency_stb", stb[0], 1);
      wait_ack(0);
      strobe(0, 16'h9999, 4'b0000, 4'b0000);
      wait_ack(0);
      strobe(0, 16'h5555, 4'b0000, 4'b0000);
      wait_ack(0);
      wait_ack(0);
      tick();
      check(0, "done_after_last_ack", done[0], 1);
      tick();
      check(0, "pending_gap_idle", cyc[0], 0);
      tick();
      check(0, "pending_start", cyc[0], 1);
      wait_done(0);
      repeat (60) tick();
      strobe(0, 16'h8888, 4'b0000, 4'b0100);
      wait_done(0);
      for (int it = 0; it < 10; it++) begin
         wait_idle(0);
         repeat ($urandom_range(0, 3)) tick();
         strobe(0, 16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            wait_ack(0);
            strobe(0, 16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 1) == 1) begin
               wait_ack(0);
               strobe(0, 16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
            end
         end
         wait_done(0);
      end
   endtask

   task automatic dut1_seq();
      wait_done(1);
      repeat (50) tick();
      strobe(1, 16'hAF0E, 4'b0001, 4'b0000);
      wait_done(1);
      wait_done(1);
      for (int it = 0; it < 2; it++) begin
         strobe(1, 16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
         wait_done(1);
         wait_done(1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         digits[i] = '0; dp[i] = '0; blank[i] = '0; upd[i] = 1'b0;
      end
      repeat (3) tick();
      for (int i = 0; i < 2; i++) begin
         check(i, "rst_cyc", cyc[i], 0);
         check(i, "rst_stb", stb[i], 0);
         check(i, "rst_data", data[i], 0);
         check(i, "rst_busy", busy[i], 0);
         check(i, "rst_done", done[i], 0);
      end
      rst_n = 1'b1;
      fork
         dut0_seq();
         dut1_seq();
      join
      wait_idle(0);
      strobe(0, 16'($urandom), 4'($urandom), 4'b0000);
      wait_ack(0);
      wait_ack(0);
      rst_n = 1'b0;
      tick();
      check(0, "midrst_cyc", cyc[0], 0);
      check(0, "midrst_stb", stb[0], 0);
      check(0, "midrst_data", data[0], 0);
      check(0, "midrst_busy", busy[0], 0);
      check(0, "midrst_done", done[0], 0);
      check(1, "midrst_cyc", cyc[1], 0);
      rst_n = 1'b1;
      repeat (3) tick();
      strobe(0, 16'hC0DE, 4'b1010, 4'b0000);
      wait_done(0);
      wait_done(1);
      repeat (5) tick();
      check(0, "queue_drained", exp_q[0].size(), 0);
      check(1, "queue_drained", exp_q[1].size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
